// File: rtl/sha_pad_pkg.sv
// Shared definitions for the SHA-256 padding stage and its receive-side stripper.
package sha_pad_pkg;
    localparam int BLOCK_W = 512;
    localparam int LEN_W   = 64;
    localparam int MSG_MAX = 447;
    localparam int LEN_POS = 448;

    typedef enum logic [1:0] {
        COLLECT,
        CHECK,
        HOLD
    } pad_strip_state_t;

    // Decoded block: message is left-aligned, msg[LEN_POS-1] is block bit 0.
    typedef struct packed {
        logic [LEN_POS-1:0] msg;
        logic [8:0]         len;
        logic               err;
    } pad_strip_res_t;
endpackage

// File: rtl/pad_check.sv
// Combinational decode of one padded block into message, length and error.
// Full validation is built only when PAD_STRIP_CHECK_EN is defined.
module pad_check
    import sha_pad_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk,
    output pad_strip_res_t     res
);
    logic [LEN_W-1:0]   len_f;
    logic [LEN_POS-1:0] body;
    logic [8:0]         len_out;

    // Block bit i lives at blk[BLOCK_W-1-i], so the length field is blk[63:0].
    assign len_f = blk[LEN_W-1:0];
    assign body  = blk[BLOCK_W-1:LEN_W];

`ifdef PAD_STRIP_CHECK_EN
    logic               len_ok, marker_ok, fill_ok;
    logic [8:0]         len_sel;
    logic [LEN_POS-1:0] fill_mask;

    always_comb begin
        len_ok    = (len_f <= LEN_W'(MSG_MAX));
        len_sel   = len_ok ? len_f[8:0] : 9'd0;
        marker_ok = body[9'(MSG_MAX) - len_sel];
        fill_mask = {LEN_POS{1'b1}} >> (len_sel + 9'd1);
        fill_ok   = ~|(body & fill_mask);
        res.err   = !(len_ok && marker_ok && fill_ok);
        len_out   = res.err ? 9'd0 : len_sel;
    end
`else
    always_comb begin
        res.err = 1'b0;
        len_out = (len_f > LEN_W'(MSG_MAX)) ? 9'(MSG_MAX) : len_f[8:0];
    end
`endif

    // Keep the top len_out bits; a zero length (and thus any error) clears the message.
    assign res.msg = body & ~({LEN_POS{1'b1}} >> len_out);
    assign res.len = len_out;
endmodule

// File: rtl/pad_strip.sv
// Collects one 512-bit padded block from a word stream, validates and strips the
// SHA-256 padding. PAD_STRIP_CHECK_EN enables marker/fill/length validation.
module pad_strip
    import sha_pad_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort_i,
    input  logic [DATA_W-1:0]  in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [LEN_POS-1:0] msg_o,
    output logic [8:0]         len_o,
    output logic               err_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);
    localparam int NWORDS = BLOCK_W / DATA_W;
    localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    pad_strip_state_t   state, state_nxt;
    logic [WCNT_W-1:0]  wcnt;
    logic [BLOCK_W-1:0] blk;
    pad_strip_res_t     chk_res, res_q;
    logic               hs, last;

    assign hs   = in_valid_i && in_ready_o;
    assign last = (wcnt == WCNT_W'(NWORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (!abort_i && hs && last) state_nxt = CHECK;
            CHECK:   state_nxt = HOLD;
            HOLD:    if (out_ready_i) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == COLLECT);
        out_valid_o = (state == HOLD);
    end

    // Abort takes priority over a same-cycle handshake, dropping that word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            blk  <= '0;
        end else if (state == COLLECT) begin
            if (abort_i) begin
                wcnt <= '0;
                blk  <= '0;
            end else if (hs) begin
                for (int w = 0; w < NWORDS; w++)
                    if (wcnt == WCNT_W'(w))
                        blk[(NWORDS-1-w)*DATA_W +: DATA_W] <= in_data_i;
                wcnt <= last ? '0 : wcnt + WCNT_W'(1);
            end
        end
    end

    pad_check u_pad_check (
        .blk (blk),
        .res (chk_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              res_q <= '0;
        else if (state == CHECK) res_q <= chk_res;
    end

    assign msg_o = res_q.msg;
    assign len_o = res_q.len;
    assign err_o = res_q.err;
endmodule

// File: tb/tb_pad_strip.sv
// Randomized self-checking bench for pad_strip with a bit-array reference model.
module tb_pad_strip;
    localparam int DW = 32;
    localparam int NW = 512 / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          abort_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [447:0]  msg_o;
    logic [8:0]    len_o;
    logic          err_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;

    pad_strip #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .abort_i(abort_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .msg_o(msg_o), .len_o(len_o), .err_o(err_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [447:0] msg;
        logic [8:0]   len;
        logic         err;
    } res_t;

    int   n_chk = 0;
    int   n_pass = 0;
    int   bp_mode = 2;    // 0 random, 1 hold low, 2 hold high
    bit   gaps = 1'b1;
    res_t exp_q[$];
    bit   blk[512];       // blk[0] is the first bit on the wire

    task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: decode straight from the padding rules over the bit array.
    function automatic res_t model();
        res_t r;
        longint unsigned L = 0;
        bit ok;
        r.msg = '0;
        for (int i = 448; i < 512; i++) L = (L << 1) | longint'(blk[i]);
`ifdef PAD_STRIP_CHECK_EN
        ok = (L <= 447);
        if (ok) begin
            if (!blk[int'(L)]) ok = 1'b0;
            for (int j = int'(L) + 1; j < 448; j++) if (blk[j]) ok = 1'b0;
        end
        r.err = !ok;
        r.len = ok ? L[8:0] : 9'd0;
`else
        r.err = 1'b0;
        r.len = (L > 447) ? 9'd447 : L[8:0];
`endif
        for (int i = 0; i < int'(r.len); i++) r.msg[447-i] = blk[i];
        return r;
    endfunction

    task automatic set_len(input longint unsigned L);
        for (int i = 0; i < 64; i++) blk[511-i] = L[i];
    endtask

    task automatic build(input int mlen, input longint unsigned L);
        for (int i = 0; i < 512; i++) blk[i] = 1'b0;
        for (int i = 0; i < mlen; i++) blk[i] = 1'($urandom % 2);
        if (mlen < 448) blk[mlen] = 1'b1;
        set_len(L);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int t = 0;
        in_valid_i = 1'b1;
        in_data_i  = w;
        while (!in_ready_o && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            $display("FAIL word_accept: in_ready_o stuck at %0b, expected 1", in_ready_o);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic send_block();
        logic [DW-1:0] w;
        exp_q.push_back(model());
        for (int k = 0; k < NW; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int i = 0; i < g; i++) begin
                    in_valid_i = 1'b0;
                    in_data_i  = $urandom;
                    @(posedge clk); #1;
                end
            end
            for (int b = 0; b < DW; b++) w[DW-1-b] = blk[k*DW + b];
            send_word(w);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid_o && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_valid", 448'(out_valid_o), 448'(1));
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0:       out_ready_i = ($urandom % 3) != 0;
                1:       out_ready_i = 1'b0;
                default: out_ready_i = 1'b1;
            endcase
        end
    end

    // Every cycle a result is presented it must match the oldest outstanding block.
    always @(negedge clk) begin
        if (rst_n && out_valid_o) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: out_valid_o=1, expected 0");
            end else begin
                chk("msg", msg_o, exp_q[0].msg);
                chk("len", 448'(len_o), 448'(exp_q[0].len));
                chk("err", 448'(err_o), 448'(exp_q[0].err));
                chk("in_ready_hold", 448'(in_ready_o), 448'(0));
                if (out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        res_t r;
        logic [447:0] lit;
        lit = {256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 192'h0};

        #12;
        chk("rst_valid", 448'(out_valid_o), 448'(0));
        chk("rst_msg", msg_o, 448'(0));
        chk("rst_len", 448'(len_o), 448'(0));
        chk("rst_err", 448'(err_o), 448'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 448'(in_ready_o), 448'(1));

        // 256-bit message of bytes 0x00..0x1F, timing pinned
        for (int i = 0; i < 512; i++) blk[i] = 1'b0;
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 8; j++) blk[8*k+j] = 1'((k >> (7 - j)) & 1);
        blk[256] = 1'b1;
        set_len(256);
        r = model();
        chk("pin256_msg", r.msg, lit);
        chk("pin256_len", 448'(r.len), 448'(256));
        chk("pin256_err", 448'(r.err), 448'(0));
        gaps = 1'b0;
        send_block();
        chk("lat_check_valid", 448'(out_valid_o), 448'(0));
        chk("lat_check_ready", 448'(in_ready_o), 448'(0));
        @(posedge clk); #1;
        chk("lat_hold_valid", 448'(out_valid_o), 448'(1));
        drain();
        gaps = 1'b1;

        // empty and maximum messages
        for (int i = 0; i < 512; i++) blk[i] = 1'b0;
        blk[0] = 1'b1;
        set_len(0);
        r = model();
        chk("pin_empty_len", 448'(r.len), 448'(0));
        chk("pin_empty_err", 448'(r.err), 448'(0));
        send_block();
        build(447, 447);
        r = model();
        chk("pin_max_len", 448'(r.len), 448'(447));
        chk("pin_max_err", 448'(r.err), 448'(0));
        send_block();

        // length field out of range
        build(447, 448);
        r = model();
`ifdef PAD_STRIP_CHECK_EN
        chk("pin_l448_err", 448'(r.err), 448'(1));
`else
        chk("pin_l448_len", 448'(r.len), 448'(447));
`endif
        send_block();
        build(256, 64'h0000_0100_0000_0100);
        send_block();
        build(256, 256);
        blk[256] = 1'b0;
        send_block();
        build(256, 256);
        blk[300] = 1'b1;
        r = model();
`ifdef PAD_STRIP_CHECK_EN
        chk("pin_fill_err", 448'(r.err), 448'(1));
`else
        chk("pin_fill_len", 448'(r.len), 448'(256));
`endif
        send_block();
        build(200, 500);
        r = model();
`ifdef PAD_STRIP_CHECK_EN
        chk("pin_l500_err", 448'(r.err), 448'(1));
`else
        chk("pin_l500_len", 448'(r.len), 448'(447));
        chk("pin_l500_err", 448'(r.err), 448'(0));
`endif
        send_block();
        drain();

        // back-pressure with a word waiting on the input
        bp_mode = 1;
        build(123, 123);
        send_block();
        wait_valid();
        in_valid_i = 1'b1;
        in_data_i  = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 448'(out_valid_o), 448'(1));
            chk("bp_in_ready", 448'(in_ready_o), 448'(0));
        end
        in_valid_i = 1'b0;
        bp_mode = 2;
        build(77, 77);
        send_block();
        drain();

        // abort after 7 words, with a word offered on the abort cycle
        for (int i = 0; i < 7; i++) send_word($urandom);
        in_valid_i = 1'b1;
        in_data_i  = $urandom;
        abort_i    = 1'b1;
        @(posedge clk); #1;
        abort_i    = 1'b0;
        in_valid_i = 1'b0;
        build(311, 311);
        send_block();
        drain();

        // reset after 9 words
        for (int i = 0; i < 9; i++) send_word($urandom);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_msg", msg_o, 448'(0));
        chk("mid_rst_len", 448'(len_o), 448'(0));
        chk("mid_rst_err", 448'(err_o), 448'(0));
        chk("mid_rst_valid", 448'(out_valid_o), 448'(0));
        chk("mid_rst_wcnt", 448'(dut.wcnt), 448'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        build(400, 400);
        send_block();
        drain();

        // randomized blocks, some corrupted, with random back-pressure
        bp_mode = 0;
        for (int n = 0; n < 40; n++) begin
            int mlen = $urandom_range(0, 447);
            build(mlen, longint'(mlen));
            case ($urandom % 5)
                1: blk[mlen] = 1'b0;
                2: if (mlen < 447) blk[$urandom_range(mlen + 1, 447)] = 1'b1;
                3: set_len(longint'($urandom_range(448, 511)));
                4: set_len({32'($urandom), 32'($urandom)});
                default: ;
            endcase
            send_block();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, expected finish", $time);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "timeout");
    end
endmodule
